// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// State encoding, reset PC default and NOP word.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int CNT_W = 8;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
// The fetch unit is the master, the memory the slave.
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int WIDTH = XLEN
) ();

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit_fetch_timeout_ctr.sv
// Counts consecutive unacknowledged request cycles and
// raises a sticky error once the wait reaches TIMEOUT.
module fetch_timeout_ctr
    import if_fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic fetch_err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] wait_cnt;

    // Saturate so a long stall cannot wrap back below LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else if (req && !ack) begin
            if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + ONE;
            end
            if (wait_cnt == LAST) begin
                fetch_err <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to imem over
// req/ack and feeds {instr, pc+4} to the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter int               TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    if_fetch_unit_if.master  imem,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc4,
    output logic             if_id_enable_bar,
    output logic             if_id_rst,
    output logic             fetch_err
);

    localparam logic [WIDTH-1:0] NOP_W  = WIDTH'(NOP);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(PC_STEP);

    fetch_state_e     state;
    fetch_state_e     state_n;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_n;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_addr_n;
    logic [WIDTH-1:0] ibuf;
    logic [WIDTH-1:0] ibuf_n;
    logic [WIDTH-1:0] pending_pc;
    logic [WIDTH-1:0] pending_n;

    logic             pc4;
    logic [WIDTH-1:0] pc_plus4;
    logic             ack;
    logic [WIDTH-1:0] rdata;
    logic             req_c;
    logic             req_o;
    logic [WIDTH-1:0] addr_c;
    logic             valid_c;
    logic [WIDTH-1:0] instr_c;

    assign pc4      = 1'b0;
    assign pc_plus4 = pc + STEP_W;
    assign ack      = imem.imem_ack;
    assign rdata    = imem.imem_rdata;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        req_addr_n = req_addr;
        ibuf_n     = ibuf;
        pending_n  = pending_pc;
        req_c      = 1'b0;
        addr_c     = pc;
        valid_c    = 1'b0;
        instr_c    = NOP_W;

        unique case (state)
            FETCH: begin
                req_c   = 1'b1;
                addr_c  = pc;
                valid_c = ack;
                instr_c = ack ? rdata : NOP_W;
                unique case (1'b1)
                    redirect && ack: begin
                        pc_n = redirect_pc;
                    end
                    // Request in flight cannot be withdrawn.
                    redirect && !ack: begin
                        pending_n  = redirect_pc;
                        req_addr_n = pc;
                        state_n    = DRAIN;
                    end
                    !redirect && ack && !stall: begin
                        pc_n = pc_plus4;
                    end
                    !redirect && ack && stall: begin
                        ibuf_n  = rdata;
                        state_n = HOLD;
                    end
                    default: begin
                    end
                endcase
            end

            HOLD: begin
                valid_c = 1'b1;
                instr_c = ibuf;
                unique case (1'b1)
                    redirect: begin
                        pc_n    = redirect_pc;
                        state_n = FETCH;
                    end
                    !redirect && !stall: begin
                        pc_n    = pc_plus4;
                        state_n = FETCH;
                    end
                    default: begin
                    end
                endcase
            end

            DRAIN: begin
                req_c  = 1'b1;
                addr_c = req_addr;
                if (redirect) begin
                    pending_n = redirect_pc;
                end
                if (ack) begin
                    pc_n    = redirect ? redirect_pc
                                       : pending_pc;
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            ibuf       <= NOP_W;
            pending_pc <= RESET_PC;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_addr   <= req_addr_n;
            ibuf       <= ibuf_n;
            pending_pc <= pending_n;
        end
    end

    // Reset abandons any outstanding request immediately.
    assign req_o          = req_c & ~rst;
    assign imem.imem_req  = req_o;
    assign imem.imem_addr = addr_c;

    assign out_valid = valid_c & ~rst;
    assign out_instr = (valid_c && !rst) ? instr_c : NOP_W;
    assign out_pc4   = pc_plus4 | {{(WIDTH-1){1'b0}}, pc4};

    assign if_id_enable_bar = stall;
    assign if_id_rst        = redirect;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .req       (req_o),
        .ack       (ack),
        .fetch_err (fetch_err)
    );

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register (M_S_FF instance).
- Owns the PC and issues requests to a variable-latency instruction memory over a req/ack handshake.
- Presents {instr, pc+4} to IF/ID and drives that register's enable_bar and rst pins.
- Handles stall, branch/jump redirect (flush), and fetch timeout.

Parameters:
WIDTH, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles a request may wait for ack before fetch_err is set (range 2..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: ID cannot accept a new instruction this cycle
redirect  in  1  EX/ID: branch taken or jump; flush IF/ID, refetch from redirect_pc
redirect_pc  in  WIDTH  redirect target; word aligned
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  WIDTH  fetch address; stable while imem_req=1 and no ack
imem_ack  in  1  memory returns imem_rdata this cycle; ignored when imem_req=0
imem_rdata  in  WIDTH  instruction word
out_valid  out  1  out_instr/out_pc4 carry a real instruction
out_instr  out  WIDTH  instruction to IF/ID; forced 0 (NOP) when out_valid=0
out_pc4  out  WIDTH  address of out_instr + 4
if_id_enable_bar  out  1  to IF/ID enable_bar; equals stall
if_id_rst  out  1  to IF/ID rst; equals redirect
fetch_err  out  1  sticky: request waited TIMEOUT cycles without ack; cleared only by rst

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=FETCH, wait_cnt=0, fetch_err=0, buf=0.
  - While rst=1: imem_req=0 and out_valid=0.
- States FETCH, HOLD, DRAIN. Registers: pc, req_addr, buf, pending_pc, wait_cnt.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - out_valid=imem_ack, out_instr=imem_rdata, out_pc4=pc+4. Combinational pass-through gives zero-wait memory 1 instr/cycle.
  - redirect=1 and imem_ack=1: pc<=redirect_pc, stay FETCH; returned word discarded.
  - redirect=1 and imem_ack=0: pending_pc<=redirect_pc, req_addr<=pc, go DRAIN. The request cannot be withdrawn.
  - imem_ack=1, stall=0: pc<=pc+4, stay FETCH.
  - imem_ack=1, stall=1: buf<=imem_rdata, go HOLD; pc unchanged.
  - imem_ack=0: stay; wait_cnt+1.
- HOLD:
  - imem_req=0, out_valid=1, out_instr=buf, out_pc4=pc+4.
  - redirect=1: pc<=redirect_pc, go FETCH. Redirect has priority over stall.
  - stall=0: pc<=pc+4, go FETCH. IF/ID loads buf this edge.
  - stall=1: stay.
- DRAIN:
  - imem_req=1, imem_addr=req_addr, out_valid=0.
  - redirect=1 overwrites pending_pc, in the same cycle as ack as well.
  - imem_ack=1: pc<=pending_pc (or redirect_pc if redirect=1 this cycle), go FETCH; data discarded.
- Priority at every edge: rst > redirect > stall > normal advance.
- wait_cnt:
  - Counts consecutive cycles with imem_req=1 and imem_ack=0; cleared on ack or on leaving a requesting state.
  - At wait_cnt==TIMEOUT-1 with no ack, fetch_err<=1 next edge. Fetching continues.
- Arithmetic: pc+4 is modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0 without error.
- Mid-operation reset: an outstanding request is abandoned. Memory must tolerate req dropping at reset, which is the only legal withdrawal.

Decomposition:
- Shared pipeline package holds:
  - WIDTH default
  - RESET_PC
  - NOP encoding (32'h0)
  - State encoding: FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2
- One natural sub-module: fetch_timeout_ctr (wait counter + sticky error flag), parameterised by TIMEOUT.
- The IF/ID register stays external, driven by if_id_enable_bar and if_id_rst.

Test Plan:
1. Reset then zero-wait memory (ack tied 1, rdata=addr|32'hA000_0000): imem_addr sequence 0,4,8,C on consecutive cycles; out_pc4 4,8,C,10; out_valid=1 every cycle.
2. 3-cycle memory latency: req stays high with addr 0 for 3 cycles, out_valid=0 (out_instr=0) until ack; fetch_err stays 0.
3. Stall=1 for 2 cycles coincident with ack at addr 8:
   - HOLD keeps out_instr = word@8 and if_id_enable_bar=1.
   - Next request is addr C only after stall drops.
4. Redirect to 32'h0000_0100 while a request to 14 is pending (2 more wait cycles):
   - DRAIN holds addr 14 until ack; word discarded (out_valid=0).
   - Next request is 100; if_id_rst=1 exactly in the redirect cycle.
5. Redirect and stall both high in HOLD: pc becomes redirect_pc, if_id_rst=1, next imem_addr=redirect_pc.
6. TIMEOUT=4, ack withheld 6 cycles: fetch_err rises after 4 wait cycles, stays 1 after ack; PC wrap check RESET_PC=32'hFFFF_FFFC → next addr 0. rst clears fetch_err.
